// File: rtl/nand_four_pkg.sv
// nand_four_pkg: shared constants for the registered NAND network.
// Reset values match the NAND results for all-zero operands.
package nand_four_pkg;

    // Output flop reset values
    localparam logic E_RST = 1'b1;
    localparam logic F_RST = 1'b1;
    localparam logic G_RST = 1'b0;

    // Default depth of each input synchronizer chain
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // Smallest synchronizer depth that gives metastability protection
    localparam int unsigned SYNC_STAGES_MIN = 2;

    // Operand bundle as seen by the NAND logic
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } operands_t;

endpackage : nand_four_pkg

// File: rtl/nand_four_nand2_cell.sv
// nand2_cell: pure combinational 2-input NAND, the only gate used in nand_four.
module nand2_cell (
    input  logic x,
    input  logic y,
    output logic z
);

    assign z = ~(x & y);

endmodule : nand2_cell

// File: rtl/nand_four.sv
// nand_four: registered NAND network, g = (a & b) | (c & d) built from three NANDs.
// Optional input synchronizer enabled by defining NAND_FOUR_SYNC_EN; without it the
// operands feed the NAND logic directly and SYNC_STAGES has no effect.
module nand_four
    import nand_four_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e,
    output logic f,
    output logic g
);

    operands_t ops_raw;
    operands_t ops;

    logic e_d;
    logic f_d;
    logic g_d;
    logic e_q;
    logic f_q;
    logic g_q;

    assign ops_raw = '{a: a, b: b, c: c, d: d};

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_illegal_sync_stages
        $error("nand_four: SYNC_STAGES must be 2 or more");
    end

`ifdef NAND_FOUR_SYNC_EN
    // Each operand bit gets its own chain, so simultaneous changes may land a cycle apart
    logic [3:0] ops_sync;

    for (genvar i = 0; i < 4; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain_q;
        logic [SYNC_STAGES-1:0] chain_d;

        // Next chain value: shift the raw operand in at stage 0
        always_comb begin
            chain_d = {chain_q[SYNC_STAGES-2:0], ops_raw[i]};
        end

        // Synchronizer chain register, cleared by reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain_q <= '0;
            end else begin
                chain_q <= chain_d;
            end
        end

        assign ops_sync[i] = chain_q[SYNC_STAGES-1];
    end

    assign ops = operands_t'(ops_sync);
`else
    assign ops = ops_raw;
`endif

    // First level: one NAND per operand pair
    nand2_cell u_cell1 (
        .x (ops.a),
        .y (ops.b),
        .z (e_d)
    );

    nand2_cell u_cell2 (
        .x (ops.c),
        .y (ops.d),
        .z (f_d)
    );

    // Second level uses the unregistered first-level results so g stays coherent with e and f
    nand2_cell u_cell3 (
        .x (e_d),
        .y (f_d),
        .z (g_d)
    );

    // Output registers: all three load together every cycle, reset wins immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= E_RST;
            f_q <= F_RST;
            g_q <= G_RST;
        end else begin
            e_q <= e_d;
            f_q <= f_d;
            g_q <= g_d;
        end
    end

    assign e = e_q;
    assign f = f_q;
    assign g = g_q;

endmodule : nand_four

// File: tb/tb_nand_four.sv
// tb_nand_four: directed self-checking bench for nand_four.
module tb_nand_four;

    localparam int SYNC_STAGES = 2;
`ifdef NAND_FOUR_SYNC_EN
    localparam int LAT = SYNC_STAGES + 1;
`else
    localparam int LAT = 1;
`endif

    // Hand-computed result tables indexed by {a,b,c,d}
    localparam logic [15:0] E_TAB = 16'h0FFF;
    localparam logic [15:0] F_TAB = 16'h7777;
    localparam logic [15:0] G_TAB = 16'hF888;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;

    int checks = 0;
    int errors = 0;

    logic [3:0] hist[$];
    logic [3:0] past;

    nand_four #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .g   (g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic ee, input logic fe, input logic ge);
        check({tag, ".e"}, e, ee);
        check({tag, ".f"}, f, fe);
        check({tag, ".g"}, g, ge);
    endtask

    initial begin
        // Reset with all operands high and no clock edge yet
        rst = 1'b1;
        {a, b, c, d} = 4'b1111;
        #1;
        check3("reset_immediate", 1'b1, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check3("reset_held", 1'b1, 1'b1, 1'b0);
        end

        @(negedge clk);
        rst = 1'b0;
        {a, b, c, d} = 4'b0000;

        // Exhaustive sweep against hand tables
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vec;
            vec = v[3:0];
            @(negedge clk);
            {a, b, c, d} = vec;
            repeat (LAT) @(posedge clk);
            #1;
            check3($sformatf("sweep_%0h", vec), E_TAB[v], F_TAB[v], G_TAB[v]);
        end

        // Named spot vectors
        @(negedge clk);
        {a, b, c, d} = 4'b1100;
        repeat (LAT) @(posedge clk);
        #1;
        check3("ab_only", 1'b0, 1'b1, 1'b1);

        @(negedge clk);
        {a, b, c, d} = 4'b1111;
        repeat (LAT) @(posedge clk);
        #1;
        check3("all_ones", 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        {a, b, c, d} = 4'b1001;
        repeat (LAT) @(posedge clk);
        #1;
        check3("a_d_only", 1'b1, 1'b1, 1'b0);

        // Free-running toggles: a/b/c/d every 20/30/40/50 ns for 1000 ns
        @(negedge clk);
        {a, b, c, d} = 4'b0000;
        hist.delete();
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            hist.push_front({a, b, c, d});
            #1;
            if (hist.size() >= LAT) begin
                past = hist[LAT-1];
                check($sformatf("toggle_%0d.e", k), e, ~(past[3] & past[2]));
                check($sformatf("toggle_%0d.f", k), f, ~(past[1] & past[0]));
                check($sformatf("toggle_%0d.g", k), g,
                      (past[3] & past[2]) | (past[1] & past[0]));
            end
            @(negedge clk);
            if ((k * 10) % 20 == 0) a = ~a;
            if ((k * 10) % 30 == 0) b = ~b;
            if ((k * 10) % 40 == 0) c = ~c;
            if ((k * 10) % 50 == 0) d = ~d;
        end

        // Mid-run reset while e=0, g=1
        {a, b, c, d} = 4'b1100;
        repeat (LAT + 1) @(posedge clk);
        #1;
        check3("pre_midreset", 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check3("midreset_immediate", 1'b1, 1'b1, 1'b0);
        {a, b, c, d} = 4'b0011;
        @(posedge clk);
        #1;
        check3("midreset_held", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
`ifdef NAND_FOUR_SYNC_EN
        check3("post_release_first", 1'b1, 1'b1, 1'b0);
`else
        check3("post_release_first", 1'b1, 1'b0, 1'b1);
`endif
        repeat (LAT - 1) @(posedge clk);
        #1;
        check3("post_release_settled", 1'b1, 1'b0, 1'b1);

`ifdef NAND_FOUR_SYNC_EN
        // Synchronizer latency: a=b step must take SYNC_STAGES+1 edges to reach g
        @(negedge clk);
        {a, b, c, d} = 4'b0000;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        {a, b} = 2'b11;
        @(posedge clk);
        #1;
        check("sync_edge1.g", g, 1'b0);
        @(posedge clk);
        #1;
        check("sync_edge2.g", g, 1'b0);
        @(posedge clk);
        #1;
        check("sync_edge3.g", g, 1'b1);
        check("sync_edge3.e", e, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nand_four

// File: doc/nand_four.md
# nand_four

- Registered NAND network: three 2-input NAND cells combine four single-bit inputs into two first-level NAND results and one second-level result.
- Used as the NAND-universality reference cell: `g` equals (a AND b) OR (c AND d), built only from NANDs.
- All outputs are registered on one clock.
- An optional input synchronizer allows the inputs to come from asynchronous sources.

## Interface
Parameters:
- SYNC_STAGES, default 2: flop depth of each input synchronizer. Legal values are 2 or more. It has effect only when NAND_FOUR_SYNC_EN is defined.

Ports:
- clk, input, 1 bit: single rising-edge clock.
- rst, input, 1 bit: reset, asynchronous and active-high.
- a, input, 1 bit: first operand of NAND cell 1.
- b, input, 1 bit: second operand of NAND cell 1.
- c, input, 1 bit: first operand of NAND cell 2.
- d, input, 1 bit: second operand of NAND cell 2.
- e, output, 1 bit: registered ~(a & b).
- f, output, 1 bit: registered ~(c & d).
- g, output, 1 bit: registered ~(e_next & f_next), which equals (a & b) | (c & d).

## Operation
- Next-state values are computed combinationally from the operand inputs:
  - e_next = ~(a & b)
  - f_next = ~(c & d)
  - g_next = ~(e_next & f_next)
- g_next is computed from the unregistered e_next and f_next, not from the e and f flops. This keeps g coherent with e and f in the same cycle.
- All three outputs load together on each rising edge of clk. There is no enable and no handshake, so every cycle is a new sample.
- Reset values: e=1, f=1, g=0. These are the results for all-zero inputs.
- rst asserted:
  - Outputs and any synchronizer flops clear immediately, regardless of clk.
  - Synchronizer flops clear to 0.
- rst deasserted: the first load happens at the first rising clk edge after deassertion.
- Reset asserted mid-operation: the reset values win immediately, and no pending sample survives.
- Truth coverage: all 16 input combinations are legal. g=1 exactly when (a&b) or (c&d).

## Timing
- Without the macro:
  - Latency is 1 cycle: inputs stable before edge N appear on outputs after edge N.
  - Inputs must meet setup and hold to clk.
- With the macro:
  - Latency is SYNC_STAGES+1 cycles: 3 cycles at the default.
  - Inputs may change at any time.
  - Each input is synchronized independently, so a simultaneous multi-input change can appear split across one extra cycle. This is accepted.
- Outputs are glitch-free because they come straight from flops.
- No combinational path runs from input to output.

## Configuration
- NAND_FOUR_SYNC_EN defined: each of a, b, c, d passes through its own SYNC_STAGES-deep flop chain before the NAND logic. The chains are reset to 0 by rst.
- NAND_FOUR_SYNC_EN undefined:
  - Inputs feed the NAND logic directly.
  - SYNC_STAGES is ignored.
  - Latency is 1 cycle.

## Structure
- Package nand_four_pkg holds:
  - Reset constants: E_RST=1'b1, F_RST=1'b1, G_RST=1'b0.
  - Default SYNC_STAGES=2.
- Sub-module nand2_cell: a pure combinational 2-input NAND (inputs x, y; output z).
  - Instantiated three times: cell 1 (a,b), cell 2 (c,d), cell 3 (e_next,f_next).
- Synchronizer: a generate loop inside nand_four, guarded by the macro.

## Test plan
- Reset: assert rst with a=b=c=d=1 and no clock edge. Required: e=1, f=1, g=0 immediately. Hold these through clocks while rst=1.
- Exhaustive sweep, macro off: drive all 16 {a,b,c,d} values, one per cycle.
  - Each result appears 1 cycle later.
  - a=b=1, c=d=0 -> e=0, f=1, g=1.
  - a=b=c=d=1 -> e=0, f=0, g=1.
  - a=1, b=0, c=0, d=1 -> e=1, f=1, g=0.
- Free-running toggles: toggle a, b, c, d every 20, 30, 40, 50 ns for 1000 ns with a 10 ns clock.
  - Every output matches a reference model of the inputs sampled one edge earlier.
  - With the macro, the model uses the inputs sampled SYNC_STAGES+1 edges earlier.
- Mid-run reset: pulse rst while e=0 and g=1.
  - Outputs snap to 1/1/0 at once.
  - After release, the first edge loads the current inputs.
- Macro on, SYNC_STAGES=2: step a=b from 0 to 1 at edge 0.
  - g stays 0 after edges 1 and 2.
  - g becomes 1 after edge 3.
  - e becomes 0 after the same edge 3.
